// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package hilo_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_t;

    // S_ABORT is reachable only when the watchdog is built in.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_COMMIT = 3'd2,
        S_DZ     = 3'd3,
        S_ABORT  = 3'd4
    } state_t;

    function automatic logic is_unit_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_seq_ctrl_if.sv
// Command / read-stall channel between the main control FSM and the HI/LO sequencer.
interface hilo_seq_ctrl_if
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();
    logic             cmd_valid;
    op_t              cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_ready;
    logic             rd_req;
    logic             stall;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rd_req,
        input  cmd_ready, stall
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rd_req,
        output cmd_ready, stall
    );
endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO pair: independent write enables, one shared source mux
// selecting either the MTHI/MTLO operand or the committed unit result.
module hilo_regs
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             commit_sel,
    input  logic [WIDTH-1:0] mt_data,
    input  logic [WIDTH-1:0] stage_hi,
    input  logic [WIDTH-1:0] stage_lo,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);
    logic [1:0]       we;
    logic [WIDTH-1:0] stage_data [2];
    logic [WIDTH-1:0] wr_data    [2];
    logic [WIDTH-1:0] q_reg      [2];

    assign we            = {lo_we, hi_we};
    assign stage_data[0] = stage_hi;
    assign stage_data[1] = stage_lo;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_reg
            assign wr_data[gi] = commit_sel ? stage_data[gi] : mt_data;

            always_ff @(posedge Clock) begin
                if (Reset) begin
                    q_reg[gi] <= '0;
                end else if (we[gi]) begin
                    q_reg[gi] <= wr_data[gi];
                end
            end
        end
    endgenerate

    assign hi_q = q_reg[0];
    assign lo_q = q_reg[1];

endmodule

// File: rtl/hilo_seq_ctrl.sv
// Sequencer for the iterative MULT/DIV units feeding HI/LO.
// Optional macro HILO_WATCHDOG_EN adds a RUN-length watchdog and the wdog_err output.
module hilo_seq_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
`ifdef HILO_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 40
`endif
) (
    input  logic              Clock,
    input  logic              Reset,
    hilo_seq_ctrl_if.slave    bus,
    output logic              mult_start,
    input  logic              mult_stop,
    input  logic [WIDTH-1:0]  mult_hi,
    input  logic [WIDTH-1:0]  mult_lo,
    output logic              div_start,
    input  logic              div_stop,
    input  logic              div_zero,
    input  logic [WIDTH-1:0]  div_hi,
    input  logic [WIDTH-1:0]  div_lo,
    output logic              unit_rst,
    output logic [WIDTH-1:0]  hi_q,
    output logic [WIDTH-1:0]  lo_q,
    output logic              busy,
    output logic              dz_exc,
`ifdef HILO_WATCHDOG_EN
    output logic              wdog_err,
`endif
    output logic [CNT_W-1:0]  busy_cycles
);
    state_t           state_reg, state_next;
    logic             op_mul_reg;
    logic [WIDTH-1:0] stage_hi_reg, stage_lo_reg;
    logic [CNT_W-1:0] busy_cnt_reg;
    logic             rst_dly_reg;

    logic cmd_fire;
    logic run_fire;
    logic sel_stop;
    logic dz_hit;
    logic in_run;
    logic abort_hit;
    logic hi_we, lo_we, commit_sel;

    assign in_run   = (state_reg == S_RUN);
    assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
    assign run_fire = cmd_fire & is_unit_op(bus.cmd_op);
    assign sel_stop = op_mul_reg ? mult_stop : div_stop;
    assign dz_hit   = ~op_mul_reg & div_zero;

`ifdef HILO_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_cnt_reg;
    logic            wdog_err_reg;

    // Fires in the WDOG_CYCLES-th RUN cycle when neither stop nor div_zero arrived.
    assign abort_hit = in_run && (wdog_cnt_reg == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wdog_cnt_reg <= '0;
            wdog_err_reg <= 1'b0;
        end else begin
            if (run_fire) begin
                wdog_cnt_reg <= '0;
            end else if (in_run) begin
                wdog_cnt_reg <= wdog_cnt_reg + WD_W'(1);
            end
            if (state_reg == S_ABORT) begin
                wdog_err_reg <= 1'b1;
            end
        end
    end

    assign wdog_err = wdog_err_reg;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (run_fire) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Divide-by-zero outranks a simultaneous stop.
                if (dz_hit) begin
                    state_next = S_DZ;
                end else if (sel_stop) begin
                    state_next = S_COMMIT;
                end else if (abort_hit) begin
                    state_next = S_ABORT;
                end
            end
            S_COMMIT: state_next = S_IDLE;
            S_DZ:     state_next = S_IDLE;
            S_ABORT:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            op_mul_reg   <= 1'b0;
            stage_hi_reg <= '0;
            stage_lo_reg <= '0;
            busy_cnt_reg <= '0;
            rst_dly_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            rst_dly_reg <= 1'b0;
            if (run_fire) begin
                op_mul_reg   <= (bus.cmd_op == OP_MULT);
                busy_cnt_reg <= '0;
            end else if (in_run && (busy_cnt_reg != {CNT_W{1'b1}})) begin
                busy_cnt_reg <= busy_cnt_reg + CNT_W'(1);
            end
            if (in_run && sel_stop) begin
                stage_hi_reg <= op_mul_reg ? mult_hi : div_hi;
                stage_lo_reg <= op_mul_reg ? mult_lo : div_lo;
            end
        end
    end

    // Units are held in reset through Reset, the cycle after it, and every wind-down state.
    assign unit_rst = Reset | rst_dly_reg |
                      (state_reg == S_COMMIT) | (state_reg == S_DZ) | (state_reg == S_ABORT);

    assign bus.cmd_ready = (state_reg == S_IDLE) & ~unit_rst;
    assign bus.stall     = bus.rd_req & (state_reg != S_IDLE);
    assign busy          = (state_reg != S_IDLE);
    assign mult_start    = in_run & op_mul_reg;
    assign div_start     = in_run & ~op_mul_reg;
    assign dz_exc        = (state_reg == S_DZ);
    assign busy_cycles   = busy_cnt_reg;

    assign commit_sel = (state_reg == S_COMMIT);
    assign hi_we      = commit_sel | (cmd_fire & (bus.cmd_op == OP_MTHI));
    assign lo_we      = commit_sel | (cmd_fire & (bus.cmd_op == OP_MTLO));

    hilo_regs #(.WIDTH(WIDTH)) u_regs (
        .Clock      (Clock),
        .Reset      (Reset),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .commit_sel (commit_sel),
        .mt_data    (bus.cmd_data),
        .stage_hi   (stage_hi_reg),
        .stage_lo   (stage_lo_reg),
        .hi_q       (hi_q),
        .lo_q       (lo_q)
    );

endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// Bench for hilo_seq_ctrl: directed scenarios plus random traffic against a cycle-level model.
module tb_hilo_seq_ctrl;
    import hilo_pkg::*;

    localparam int W    = 32;
    localparam int CW   = 6;
    localparam int WDOG = 40;
    localparam int SATV = (1 << CW) - 1;

    logic          Clock;
    logic          Reset = 1'b1;
    logic          mult_start, div_start, unit_rst, busy, dz_exc;
    logic          mult_stop = 1'b0, div_stop = 1'b0, div_zero = 1'b0;
    logic [W-1:0]  mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;
    logic [W-1:0]  hi_q, lo_q;
    logic [CW-1:0] busy_cycles;
`ifdef HILO_WATCHDOG_EN
    logic          wdog_err;
`endif

    int total = 0;
    int bad   = 0;

    hilo_seq_ctrl_if #(.WIDTH(W)) bus ();

    hilo_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .bus         (bus),
        .mult_start  (mult_start),
        .mult_stop   (mult_stop),
        .mult_hi     (mult_hi),
        .mult_lo     (mult_lo),
        .div_start   (div_start),
        .div_stop    (div_stop),
        .div_zero    (div_zero),
        .div_hi      (div_hi),
        .div_lo      (div_lo),
        .unit_rst    (unit_rst),
        .hi_q        (hi_q),
        .lo_q        (lo_q),
        .busy        (busy),
        .dz_exc      (dz_exc),
`ifdef HILO_WATCHDOG_EN
        .wdog_err    (wdog_err),
`endif
        .busy_cycles (busy_cycles)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Model: a running job with an elapsed-cycle count, then a one-cycle tail
    // (1 = commit, 2 = divide-by-zero, 3 = watchdog abort).
    bit           m_ok = 0, m_run = 0, m_mul = 0, m_rstd = 0, m_wd = 0;
    bit           m_bz, m_rdy;
    int           m_tail = 0, m_cnt = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, m_sh = '0, m_sl = '0;

    initial forever begin
        @(negedge Clock);
        if (m_ok) begin
            m_bz = m_run || (m_tail != 0);
            chk("busy",        busy,          m_bz);
            chk("cmd_ready",   bus.cmd_ready, !m_bz && !(Reset || m_rstd));
            chk("stall",       bus.stall,     bus.rd_req && m_bz);
            chk("mult_start",  mult_start,    m_run && m_mul);
            chk("div_start",   div_start,     m_run && !m_mul);
            chk("unit_rst",    unit_rst,      Reset || m_rstd || (m_tail != 0));
            chk("dz_exc",      dz_exc,        m_tail == 2);
            chk("hi_q",        hi_q,          m_hi);
            chk("lo_q",        lo_q,          m_lo);
            chk("busy_cycles", busy_cycles,   (m_cnt > SATV) ? SATV : m_cnt);
`ifdef HILO_WATCHDOG_EN
            chk("wdog_err",    wdog_err,      m_wd);
`endif
        end
        if (Reset) begin
            m_ok = 1; m_run = 0; m_mul = 0; m_rstd = 1; m_wd = 0;
            m_tail = 0; m_cnt = 0; m_hi = '0; m_lo = '0;
        end else begin
            m_rdy  = !(m_run || (m_tail != 0)) && !m_rstd;
            m_rstd = 0;
            if (m_tail == 1) begin
                m_hi = m_sh;
                m_lo = m_sl;
            end
            if (m_tail != 0) begin
                m_tail = 0;
            end else if (m_run) begin
                m_cnt++;
                if (!m_mul && div_zero) begin
                    m_run = 0; m_tail = 2;
                end else if (m_mul ? mult_stop : div_stop) begin
                    m_sh = m_mul ? mult_hi : div_hi;
                    m_sl = m_mul ? mult_lo : div_lo;
                    m_run = 0; m_tail = 1;
                end
`ifdef HILO_WATCHDOG_EN
                else if (m_cnt >= WDOG) begin
                    m_run = 0; m_tail = 3; m_wd = 1;
                end
`endif
            end else if (m_rdy && bus.cmd_valid) begin
                case (bus.cmd_op)
                    OP_MULT: begin m_run = 1; m_mul = 1; m_cnt = 0; end
                    OP_DIV:  begin m_run = 1; m_mul = 0; m_cnt = 0; end
                    OP_MTHI: m_hi = bus.cmd_data;
                    default: m_lo = bus.cmd_data;
                endcase
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish before 1ms");
        $fatal(1, "bench timeout");
    end

    int n, ndz;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_MULT;
        bus.cmd_data  = '0;
        bus.rd_req    = 1'b0;

        // Reset state and the trailing unit reset cycle
        repeat (3) tick();
        Reset = 1'b0;
        chk("rst_unit_rst", unit_rst, 1);
        chk("rst_ready",    bus.cmd_ready, 0);
        chk("rst_hi",       hi_q, 0);
        chk("rst_lo",       lo_q, 0);
        chk("rst_cycles",   busy_cycles, 0);
        chk("rst_busy",     busy, 0);
        chk("rst_starts",   {mult_start, div_start, dz_exc}, 0);
        tick();
        chk("rst_release_ready", bus.cmd_ready, 1);
        $display("txn reset: hi=%0h lo=%0h", hi_q, lo_q);

        // MTHI then MTLO back to back
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_MTHI; bus.cmd_data = 32'hDEADBEEF;
        tick();
        chk("mthi_busy", busy, 0);
        bus.cmd_op = OP_MTLO; bus.cmd_data = 32'h12345678;
        tick();
        chk("mtlo_busy", busy, 0);
        bus.cmd_valid = 1'b0;
        chk("mt_hi", hi_q, 32'hDEADBEEF);
        chk("mt_lo", lo_q, 32'h12345678);
        $display("txn mthi/mtlo: hi=%0h lo=%0h", hi_q, lo_q);

        // DIV with stop on RUN cycle 32
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_DIV;
        tick();
        bus.cmd_valid = 1'b0; div_hi = 32'd1; div_lo = 32'd3;
        n = 0; ndz = 0;
        for (int k = 1; k <= 60; k++) begin
            if (!busy) break;
            if (div_start) n++;
            if (dz_exc) ndz++;
            div_stop = (k == 32);
            tick();
        end
        div_stop = 1'b0;
        chk("div32_start_cycles", n, 32);
        chk("div32_idle",   busy, 0);
        chk("div32_hi",     hi_q, 1);
        chk("div32_lo",     lo_q, 3);
        chk("div32_cycles", busy_cycles, 32);
        chk("div32_no_dz",  ndz, 0);
        $display("txn div: start_cycles=%0d hi=%0h lo=%0h busy_cycles=%0d", n, hi_q, lo_q, busy_cycles);

        // DIV hitting a zero divisor in its first RUN cycle
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_DIV;
        tick();
        bus.cmd_valid = 1'b0; div_zero = 1'b1; div_stop = 1'b1;
        tick();
        div_zero = 1'b0; div_stop = 1'b0;
        chk("dz_pulse",    dz_exc, 1);
        chk("dz_unit_rst", unit_rst, 1);
        tick();
        chk("dz_pulse_end", dz_exc, 0);
        chk("dz_idle",      busy, 0);
        chk("dz_hi_kept",   hi_q, 1);
        chk("dz_lo_kept",   lo_q, 3);
        $display("txn div-zero: hi=%0h lo=%0h", hi_q, lo_q);

        // MULT with MFHI held: stall spans RUN plus COMMIT; divider stop must be ignored
        mult_hi = 32'hA5A50F0F; mult_lo = 32'h1234ABCD;
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_MULT; bus.rd_req = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            if (!bus.stall) break;
            n++;
            mult_stop = (k == 5);
            div_stop  = (k == 3);
            tick();
        end
        mult_stop = 1'b0; div_stop = 1'b0;
        chk("mult_stall_cycles", n, 6);
        chk("mult_stall_low",    bus.stall, 0);
        chk("mult_hi",           hi_q, 32'hA5A50F0F);
        chk("mult_lo",           lo_q, 32'h1234ABCD);
        bus.rd_req = 1'b0;
        $display("txn mult: stall_cycles=%0d hi=%0h lo=%0h", n, hi_q, lo_q);

        // Reset in RUN cycle 10 of a DIV
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_DIV;
        tick();
        bus.cmd_valid = 1'b0;
        repeat (9) tick();
        chk("midrst_running", div_start, 1);
        Reset = 1'b1;
        tick();
        chk("midrst_idle",      busy, 0);
        chk("midrst_hi",        hi_q, 0);
        chk("midrst_lo",        lo_q, 0);
        chk("midrst_div_start", div_start, 0);
        chk("midrst_unit_rst",  unit_rst, 1);
        Reset = 1'b0;
        tick();
        chk("midrst_ready", bus.cmd_ready, 1);
        $display("txn reset-mid-run: hi=%0h lo=%0h", hi_q, lo_q);

`ifdef HILO_WATCHDOG_EN
        bus.cmd_valid = 1'b1; bus.cmd_op = OP_MULT;
        tick();
        bus.cmd_valid = 1'b0;
        n = 0;
        for (int k = 1; k <= 80; k++) begin
            if (!busy) break;
            if (mult_start) n++;
            tick();
        end
        chk("wdog_start_cycles", n, WDOG);
        chk("wdog_err_set",      wdog_err, 1);
        chk("wdog_ready",        bus.cmd_ready, 1);
        chk("wdog_hi_kept",      hi_q, 0);
        $display("txn watchdog: start_cycles=%0d wdog_err=%0d", n, wdog_err);
`endif

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            Reset         = ($urandom_range(0, 199) == 0);
            bus.cmd_valid = ($urandom_range(0, 2) == 0);
            bus.cmd_op    = op_t'($urandom_range(0, 3));
            bus.cmd_data  = $urandom;
            bus.rd_req    = $urandom_range(0, 1);
            mult_stop     = ($urandom_range(0, 7) == 0);
            div_stop      = ($urandom_range(0, 7) == 0);
            div_zero      = ($urandom_range(0, 19) == 0);
            mult_hi = $urandom; mult_lo = $urandom;
            div_hi  = $urandom; div_lo  = $urandom;
            tick();
        end
        $display("txn random: 3000 cycles hi=%0h lo=%0h", hi_q, lo_q);

        Reset = 1'b0; bus.cmd_valid = 1'b0; bus.rd_req = 1'b0;
        mult_stop = 1'b0; div_stop = 1'b0; div_zero = 1'b0;
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_seq_ctrl.md
Name: hilo_seq_ctrl

Overview:
Sequencer for the iterative multiply and divide units of the multicycle MIPS core.
- Accepts MULT/MULTU/DIV/DIVU commands from the main control FSM.
- Drives the selected unit's level-held start line and waits for its stop flag.
- Commits results into the architectural HI/LO registers.
- Stalls MFHI/MFLO until in-flight results land; flags divide-by-zero to the exception logic.

Parameters:
WIDTH, 32, datapath width of operands, HI and LO
CNT_W, 6, width of the busy-cycle counter (saturating)
WDOG_CYCLES, 40, watchdog limit in cycles (used only with the optional feature)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
cmd_valid  in  1  control FSM issues a command this cycle
cmd_op  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
cmd_data  in  WIDTH  rs value for MTHI/MTLO (ignored otherwise)
cmd_ready  out  1  command accepted this cycle (IDLE only)
rd_req  in  1  control FSM wants HI or LO (MFHI/MFLO)
stall  out  1  high while rd_req and a result is pending
mult_start  out  1  level start to multiplier
mult_stop  in  1  multiplier done (one-cycle pulse)
mult_hi, mult_lo  in  WIDTH each  multiplier result
div_start  out  1  level start to divider
div_stop  in  1  divider done
div_zero  in  1  divider saw zero divisor
div_hi, div_lo  in  WIDTH each  remainder / quotient
unit_rst  out  1  reset to both units
hi_q, lo_q  out  WIDTH each  architectural HI/LO
busy  out  1  state != IDLE
dz_exc  out  1  one-cycle divide-by-zero exception pulse
busy_cycles  out  CNT_W  cycles spent in last/current RUN

Behaviour:
- Reset: state IDLE; hi_q = lo_q = 0; mult_start = div_start = 0; dz_exc = 0; busy_cycles = 0; unit_rst = 1 during Reset and one cycle after.
- Reset mid-operation: same values; any pending result is discarded.
- cmd_ready = (state == IDLE) and not unit_rst. A command is taken on cmd_valid & cmd_ready.
- States:
  - IDLE:
    - MTHI/MTLO: write cmd_data into hi_q/lo_q next edge; stay in IDLE.
    - MULT/DIV: latch op; go to RUN.
  - RUN:
    - Hold the selected start line high every cycle; the units iterate only while start is high.
    - busy_cycles increments, saturating at all-ones.
    - DIV with div_zero = 1: go to DZ.
    - Selected stop = 1: capture hi/lo into staging; go to COMMIT.
  - COMMIT:
    - Drop start; write staging into hi_q/lo_q; pulse unit_rst.
    - Go to IDLE.
    - Latency: hi_q/lo_q are valid in the cycle after COMMIT.
  - DZ:
    - Drop start; pulse dz_exc for 1 cycle; pulse unit_rst; hi_q/lo_q unchanged.
    - Go to IDLE.
- stop from the non-selected unit is ignored.
- stop and div_zero in the same cycle: DZ wins.
- stall = rd_req & (state != IDLE). It is combinational, with no registered delay.
- cmd_valid outside IDLE is not accepted. The control FSM must hold it.

Optional Feature:
HILO_WATCHDOG_EN
- With the macro: if RUN lasts WDOG_CYCLES cycles with no stop, abort. Drop start, pulse unit_rst, set sticky wdog_err output (1 bit, cleared only by Reset), and return to IDLE with HI/LO unchanged.
- Without the macro: no wdog_err port; RUN waits indefinitely.

Decomposition:
Shared package hilo_pkg holds:
- op encodings OP_MULT, OP_DIV, OP_MTHI, OP_MTLO
- state encodings S_IDLE, S_RUN, S_COMMIT, S_DZ
- default WIDTH

One natural sub-module is hilo_regs: the HI/LO register pair with separate write enables and a single write mux.

Test Plan:
- DIV with the stop pulse modelled on cycle 32 of RUN, div_hi = 1, div_lo = 3 -> div_start high 32 cycles; hi_q = 1, lo_q = 3 one cycle after COMMIT; busy_cycles = 32; dz_exc stays 0.
- DIV with div_zero = 1 in the first RUN cycle -> dz_exc pulses once; hi_q/lo_q keep prior values; back in IDLE within 2 cycles.
- MTHI 0xDEADBEEF then MTLO 0x12345678 on consecutive cycles -> hi_q/lo_q hold those values; busy never rises.
- MULT issued, then rd_req held -> stall high until the cycle after COMMIT; hi_q/lo_q equal mult_hi/mult_lo when stall falls.
- Reset asserted mid-RUN (cycle 10 of DIV) -> next edge: IDLE, hi_q = lo_q = 0, div_start = 0, unit_rst high.
- With HILO_WATCHDOG_EN, WDOG_CYCLES = 40, and no stop -> abort on cycle 40; wdog_err = 1 until Reset; cmd_ready is high again.
